nibble_serial_subtractor: RTL and testbench
===========================================

// Module: nibble_serial_subtractor
// PURPOSE
//  Multi-cycle unsigned/two's-complement subtractor computing D = A - B - i_borrow_in.
//  Processes one 4-bit nibble per clock, LSB nibble first, with a 4-bit borrow-lookahead
//  slice. This is the inverse datapath to the team's carry-lookahead adder.
//  Used by the lab ALU for wide operands where a single-cycle ripple path is too slow.
// PARAMETERS
//  WIDTH  16  operand width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise)
// PORTS
//  i_clk        in   1      clock, rising edge
//  i_rst_n      in   1      asynchronous active-low reset
//  i_start      in   1      request; accepted when i_start && o_ready
//  i_a          in   WIDTH  minuend, sampled on accept edge
//  i_b          in   WIDTH  subtrahend, sampled on accept edge
//  i_borrow_in  in   1      borrow into nibble 0, sampled on accept edge
//  i_ack        in   1      consumer acknowledge of result
//  o_ready      out  1      high in IDLE only
//  o_valid      out  1      result valid; held until acknowledged
//  o_diff       out  WIDTH  difference, modulo 2^WIDTH
//  o_borrow     out  1      final borrow out (1 => A < B + borrow_in, unsigned)
//  o_zero       out  1      o_diff == 0
//  o_negative   out  1      o_diff[WIDTH-1]
//  o_overflow   out  1      signed overflow: sign(A) != sign(B) && sign(D) != sign(A)
// BEHAVIOUR
//  - Reset (async, i_rst_n=0): state=IDLE; o_ready=1; o_valid=0; o_diff=0; all flags 0.
//  - N = WIDTH/4 nibbles. Nibble counter is $clog2(N)+1 bits and never wraps while in RUN.
//  - States:
//      IDLE -> RUN   on i_start && o_ready. Latch A, B, borrow_in; clear accumulator.
//      RUN           one nibble per edge: d_k = a_k + ~b_k + ~borrow (4-bit lookahead slice,
//                    G = a&~b, P = a|~b); store d_k; carry the borrow into the next nibble.
//      RUN -> DONE   on the edge that computes nibble N-1.
//      DONE -> IDLE  on i_ack && o_valid.
//  - Latency: accept edge E0; nibble k is written at edge E(k+1); o_valid rises after E(N).
//    For WIDTH=16, o_valid is high 4 cycles after the accept edge.
//  - o_diff and flags are updated only on the RUN->DONE edge and are stable while o_valid=1.
//    o_diff and flags hold their last values through IDLE until the next DONE.
//  - Handshake:
//      i_start is ignored outside IDLE; the latched operands are unaffected.
//      i_ack is ignored unless o_valid=1.
//      i_ack and i_start asserted together in DONE: return to IDLE only; start is not accepted
//      that cycle. Minimum issue interval is N+2 cycles.
//  - Reset mid-RUN or mid-DONE: abort immediately to reset values. No partial result is exposed.
//  - N=1 (WIDTH=4): RUN lasts one cycle and is identical to a single-slice subtract.
// TESTING (WIDTH=16 unless stated)
//  1. A=0x1234, B=0x0234, bin=0 -> after 4 cycles: D=0x1000, borrow=0, zero=0, neg=0, ovf=0.
//  2. A=0x0000, B=0x0001, bin=0 -> D=0xFFFF, borrow=1, neg=1, ovf=0. Cross-nibble borrow chain.
//  3. A=0x8000, B=0x0001 -> D=0x7FFF, ovf=1, borrow=0. Also A=0x5A5A, B=0x5A5A -> D=0, zero=1.
//  4. A=0x0010, B=0x0010, bin=1 -> D=0xFFFF, borrow=1.
//     Hold i_ack=0 for 5 cycles: o_valid and o_diff stay stable.
//  5. Pulse i_start with new operands during RUN -> ignored; the original result is returned.
//     Both i_ack and i_start in DONE -> back to IDLE with no accept.
//  6. Assert i_rst_n=0 after nibble 1 -> o_valid=0, o_diff=0, o_ready=1.
//     A fresh op then completes correctly.
//     Repeat case 1 as WIDTH=4: A=0x3, B=0x5 -> D=0xE, borrow=1 after 1 cycle.

Source files
------------

// File: rtl/nibble_serial_subtractor.sv
// rtl/nibble_serial_subtractor.sv - multi-cycle subtractor, one 4-bit borrow-lookahead nibble per clock
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_borrow_in,
    input  logic             i_ack,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow,
    output logic             o_zero,
    output logic             o_negative,
    output logic             o_overflow
);

    localparam int N  = WIDTH / 4;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("nibble_serial_subtractor: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d, zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
    logic [4:0]       slice;

    // Subtract as a + ~b + ~borrow through a carry-lookahead slice; borrow out is the inverted carry.
    function automatic logic [4:0] sub_slice(input logic [3:0] a, input logic [3:0] b, input logic bin);
        logic [3:0] g, p, c;
        logic       c4;
        g    = a & ~b;
        p    = a | ~b;
        c[0] = ~bin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {~c4, a ^ ~b ^ c};
    endfunction

    assign slice = sub_slice(a_q[3:0], b_q[3:0], borrow_q);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d  = ST_RUN;
                    a_d      = i_a;
                    b_d      = i_b;
                    borrow_d = i_borrow_in;
                    acc_d    = '0;
                    cnt_d    = '0;
                    sign_a_d = i_a[WIDTH-1];
                    sign_b_d = i_b[WIDTH-1];
                end
            end
            ST_RUN: begin
                // Operands shift down so the active nibble is always bits [3:0]; result fills from the top.
                a_d              = a_q >> 4;
                b_d              = b_q >> 4;
                borrow_d         = slice[4];
                acc_d            = acc_q >> 4;
                acc_d[WIDTH-1-:4] = slice[3:0];
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                    diff_d  = acc_d;
                    bout_d  = slice[4];
                    zero_d  = (acc_d == '0);
                    neg_d   = acc_d[WIDTH-1];
                    ovf_d   = (sign_a_q != sign_b_q) && (acc_d[WIDTH-1] != sign_a_q);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (i_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
        end
    end

    assign o_ready    = (state_q == ST_IDLE);
    assign o_valid    = (state_q == ST_DONE);
    assign o_diff     = diff_q;
    assign o_borrow   = bout_q;
    assign o_zero     = zero_q;
    assign o_negative = neg_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb/tb_nibble_serial_subtractor.sv - directed-vector bench for nibble_serial_subtractor (WIDTH 16 and 4)
module tb_nibble_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start16 = 1'b0, bin16 = 1'b0, ack16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        ready16, valid16, bout16, zero16, neg16, ovf16;
    logic [15:0] diff16;
    logic        start4 = 1'b0, bin4 = 1'b0, ack4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        ready4, valid4, bout4, zero4, neg4, ovf4;
    logic [3:0]  diff4;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc;

    always #5 clk = ~clk;

    nibble_serial_subtractor #(.WIDTH(16)) u_dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start16), .i_a(a16), .i_b(b16),
        .i_borrow_in(bin16), .i_ack(ack16), .o_ready(ready16), .o_valid(valid16),
        .o_diff(diff16), .o_borrow(bout16), .o_zero(zero16), .o_negative(neg16),
        .o_overflow(ovf16)
    );

    nibble_serial_subtractor #(.WIDTH(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_a(a4), .i_b(b4),
        .i_borrow_in(bin4), .i_ack(ack4), .o_ready(ready4), .o_valid(valid4),
        .o_diff(diff4), .o_borrow(bout4), .o_zero(zero4), .o_negative(neg4),
        .o_overflow(ovf4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_op16(input logic [15:0] a, input logic [15:0] b, input logic bin);
        a16 = a; b16 = b; bin16 = bin; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
    endtask

    task automatic wait_valid16(output int n);
        n = 0;
        while (!valid16 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic check_res16(input string tag, input logic [15:0] d, input logic bo,
                               input logic z, input logic ng, input logic ov);
        check({tag, "_valid"}, 32'(valid16), 32'd1);
        check({tag, "_diff"}, 32'(diff16), 32'(d));
        check({tag, "_borrow"}, 32'(bout16), 32'(bo));
        check({tag, "_zero"}, 32'(zero16), 32'(z));
        check({tag, "_neg"}, 32'(neg16), 32'(ng));
        check({tag, "_ovf"}, 32'(ovf16), 32'(ov));
    endtask

    task automatic ack_op16(input string tag);
        ack16 = 1'b1;
        @(posedge clk); #1;
        ack16 = 1'b0;
        check({tag, "_ready_after_ack"}, 32'(ready16), 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready16), 32'd1);
        check("rst_valid", 32'(valid16), 32'd0);
        check("rst_diff", 32'(diff16), 32'd0);
        check("rst_flags", {28'd0, bout16, zero16, neg16, ovf16}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Case 1
        start_op16(16'h1234, 16'h0234, 1'b0);
        check("c1_busy", 32'(ready16), 32'd0);
        wait_valid16(cyc);
        check("c1_latency", 32'(cyc), 32'd4);
        check_res16("c1", 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
        ack_op16("c1");

        // Case 2: borrow ripples through every nibble
        start_op16(16'h0000, 16'h0001, 1'b0);
        wait_valid16(cyc);
        check("c2_latency", 32'(cyc), 32'd4);
        check_res16("c2", 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        ack_op16("c2");

        // Case 3
        start_op16(16'h8000, 16'h0001, 1'b0);
        wait_valid16(cyc);
        check_res16("c3a", 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);
        ack_op16("c3a");
        start_op16(16'h5A5A, 16'h5A5A, 1'b0);
        wait_valid16(cyc);
        check_res16("c3b", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        ack_op16("c3b");

        // Case 4: borrow-in, then result held while unacknowledged
        start_op16(16'h0010, 16'h0010, 1'b1);
        wait_valid16(cyc);
        check_res16("c4", 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("c4_hold_valid", 32'(valid16), 32'd1);
            check("c4_hold_diff", 32'(diff16), 32'hFFFF);
        end
        ack_op16("c4");

        // Case 5: start during RUN ignored; ack+start in DONE only returns to IDLE
        start_op16(16'h1234, 16'h0234, 1'b0);
        a16 = 16'h0000; b16 = 16'h0001; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        wait_valid16(cyc);
        check_res16("c5", 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
        start16 = 1'b1; ack16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0; ack16 = 1'b0;
        check("c5_ready", 32'(ready16), 32'd1);
        check("c5_valid", 32'(valid16), 32'd0);
        @(posedge clk); #1;
        check("c5_not_accepted", 32'(ready16), 32'd1);
        check("c5_diff_held", 32'(diff16), 32'h1000);

        // Case 6: reset after nibble 1, then a fresh op
        start_op16(16'hFFFF, 16'h0001, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("c6_valid", 32'(valid16), 32'd0);
        check("c6_ready", 32'(ready16), 32'd1);
        check("c6_diff", 32'(diff16), 32'd0);
        check("c6_borrow", 32'(bout16), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_op16(16'h8000, 16'h0001, 1'b0);
        wait_valid16(cyc);
        check("c6_latency", 32'(cyc), 32'd4);
        check_res16("c6", 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);
        ack_op16("c6");

        // WIDTH=4: single-slice subtract, one RUN cycle
        a4 = 4'h3; b4 = 4'h5; bin4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        cyc = 0;
        while (!valid4 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("w4_latency", 32'(cyc), 32'd1);
        check("w4_diff", 32'(diff4), 32'hE);
        check("w4_borrow", 32'(bout4), 32'd1);
        check("w4_neg", 32'(neg4), 32'd1);
        check("w4_ovf", 32'(ovf4), 32'd0);
        check("w4_zero", 32'(zero4), 32'd0);
        ack4 = 1'b1;
        @(posedge clk); #1;
        ack4 = 1'b0;
        check("w4_ready", 32'(ready4), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
